// File: rtl/axi_lite_mgr.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | axi_lite_mgr: single-outstanding cmd/rsp to AXI4-Lite manager bridge.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module axi_lite_mgr #(
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int ERR_CNT_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic                     cmd_write,
    input  logic [ADDR_WIDTH-1:0]    cmd_addr,
    input  logic [DATA_WIDTH-1:0]    cmd_wdata,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic                     rsp_write,
    output logic [DATA_WIDTH-1:0]    rsp_rdata,
    output logic [1:0]               rsp_resp,
    output logic                     busy,
    output logic [ERR_CNT_WIDTH-1:0] err_count,
    output logic [ADDR_WIDTH-1:0]    m_axi_awaddr,
    output logic                     m_axi_awvalid,
    input  logic                     m_axi_awready,
    output logic [DATA_WIDTH-1:0]    m_axi_wdata,
    output logic                     m_axi_wvalid,
    input  logic                     m_axi_wready,
    input  logic [1:0]               m_axi_bresp,
    input  logic                     m_axi_bvalid,
    output logic                     m_axi_bready,
    output logic [ADDR_WIDTH-1:0]    m_axi_araddr,
    output logic                     m_axi_arvalid,
    input  logic                     m_axi_arready,
    input  logic [DATA_WIDTH-1:0]    m_axi_rdata,
    input  logic [1:0]               m_axi_rresp,
    input  logic                     m_axi_rvalid,
    output logic                     m_axi_rready
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR_REQ  = 3'd1,
        S_WR_RESP = 3'd2,
        S_RD_REQ  = 3'd3,
        S_RD_DATA = 3'd4,
        S_RSP     = 3'd5
    } state_t;

    localparam logic [ERR_CNT_WIDTH-1:0] ERR_MAX = {ERR_CNT_WIDTH{1'b1}};

    state_t state;
    state_t state_nxt;
    logic   aw_done;
    logic   w_done;

    logic aw_hs, w_hs, b_hs, ar_hs, r_hs, rsp_hs;
    logic aw_done_nxt, w_done_nxt, err_inc;
    logic [ADDR_WIDTH-1:0] addr_aligned;

    assign aw_hs        = m_axi_awvalid & m_axi_awready;
    assign w_hs         = m_axi_wvalid  & m_axi_wready;
    assign b_hs         = m_axi_bvalid  & m_axi_bready;
    assign ar_hs        = m_axi_arvalid & m_axi_arready;
    assign r_hs         = m_axi_rvalid  & m_axi_rready;
    assign rsp_hs       = rsp_valid     & rsp_ready;
    assign aw_done_nxt  = aw_done | aw_hs;
    assign w_done_nxt   = w_done  | w_hs;
    assign addr_aligned = {cmd_addr[ADDR_WIDTH-1:2], 2'b00};
    assign err_inc      = (b_hs && (m_axi_bresp != 2'b00)) ||
                          (r_hs && (m_axi_rresp != 2'b00));

    assign cmd_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (cmd_valid) state_nxt = cmd_write ? S_WR_REQ : S_RD_REQ;
            S_WR_REQ:  if (aw_done_nxt && w_done_nxt) state_nxt = S_WR_RESP;
            S_WR_RESP: if (b_hs) state_nxt = S_RSP;
            S_RD_REQ:  if (ar_hs) state_nxt = S_RD_DATA;
            S_RD_DATA: if (r_hs) state_nxt = S_RSP;
            S_RSP:     if (rsp_hs) state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // Every AXI-facing output is its own flop, set on entry to the state that owns it.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_axi_awaddr  <= '0;
            m_axi_awvalid <= 1'b0;
            m_axi_wdata   <= '0;
            m_axi_wvalid  <= 1'b0;
            m_axi_bready  <= 1'b0;
            m_axi_araddr  <= '0;
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b0;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_write     <= 1'b0;
            rsp_rdata     <= '0;
            rsp_resp      <= 2'b00;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        if (cmd_write) begin
                            m_axi_awaddr  <= addr_aligned;
                            m_axi_wdata   <= cmd_wdata;
                            m_axi_awvalid <= 1'b1;
                            m_axi_wvalid  <= 1'b1;
                            aw_done       <= 1'b0;
                            w_done        <= 1'b0;
                        end else begin
                            m_axi_araddr  <= addr_aligned;
                            m_axi_arvalid <= 1'b1;
                        end
                    end
                end
                S_WR_REQ: begin
                    if (aw_hs) begin
                        m_axi_awvalid <= 1'b0;
                        aw_done       <= 1'b1;
                    end
                    if (w_hs) begin
                        m_axi_wvalid <= 1'b0;
                        w_done       <= 1'b1;
                    end
                    if (aw_done_nxt && w_done_nxt) begin
                        m_axi_bready <= 1'b1;
                    end
                end
                S_WR_RESP: begin
                    if (b_hs) begin
                        m_axi_bready <= 1'b0;
                        rsp_valid    <= 1'b1;
                        rsp_write    <= 1'b1;
                        rsp_rdata    <= '0;
                        rsp_resp     <= m_axi_bresp;
                    end
                end
                S_RD_REQ: begin
                    if (ar_hs) begin
                        m_axi_arvalid <= 1'b0;
                        m_axi_rready  <= 1'b1;
                    end
                end
                S_RD_DATA: begin
                    if (r_hs) begin
                        m_axi_rready <= 1'b0;
                        rsp_valid    <= 1'b1;
                        rsp_write    <= 1'b0;
                        rsp_rdata    <= m_axi_rdata;
                        rsp_resp     <= m_axi_rresp;
                    end
                end
                S_RSP: begin
                    if (rsp_hs) begin
                        rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            err_count <= '0;
        end else if (err_inc && (err_count != ERR_MAX)) begin
            err_count <= err_count + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_mgr.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_axi_lite_mgr: randomized scoreboard bench with AXI4-Lite sub model.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_axi_lite_mgr;

    logic        clk = 1'b0;
    logic        resetn;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        rsp_valid, rsp_ready, rsp_write;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        busy;
    logic [7:0]  err_count;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp;

    always #5 clk = ~clk;

    axi_lite_mgr #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ERR_CNT_WIDTH(8)) dut (
        .clk(clk), .resetn(resetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .busy(busy), .err_count(err_count),
        .m_axi_awaddr(awaddr), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
        .m_axi_wdata(wdata), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
        .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
        .m_axi_araddr(araddr), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
        .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid),
        .m_axi_rready(rready)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Knobs shaping the subordinate and the response consumer
    int aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0, rsp_hold = 0;
    bit wr_err = 0, rd_err = 0;

    typedef struct {
        bit          write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  resp;
    } exp_t;
    exp_t exp_q[$];
    logic [31:0] ref_mem [logic [31:0]];
    int ref_err = 0;

    // ---------------- AXI4-Lite subordinate model ----------------
    logic [31:0] sub_mem [logic [31:0]];
    bit   aw_got, w_got, ar_got, b_drop, r_drop, aw_pend, ar_pend;
    int   aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
    int   aw_cycles, w_cycles, last_aw_cycles, last_w_cycles;
    logic [31:0] got_awaddr, got_wdata, got_araddr, prev_awaddr, prev_araddr;
    logic [31:0] last_awaddr, last_araddr;

    always @(negedge clk) begin
        if (!resetn) begin
            aw_got = 0; w_got = 0; ar_got = 0; b_drop = 0; r_drop = 0;
            aw_pend = 0; ar_pend = 0;
            aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
            aw_cycles = 0; w_cycles = 0;
            awready = 0; wready = 0; arready = 0;
            bvalid = 0; rvalid = 0; bresp = 0; rresp = 0; rdata = 0;
        end else begin
            if (b_drop) begin bvalid = 0; b_drop = 0; end
            if (r_drop) begin rvalid = 0; r_drop = 0; end
            if (aw_got && w_got && !bvalid) begin
                if (b_cnt >= b_delay) begin
                    bvalid = 1;
                    bresp  = wr_err ? 2'b10 : 2'b00;
                    if (!wr_err) sub_mem[got_awaddr] = got_wdata;
                    aw_got = 0; w_got = 0; b_cnt = 0;
                end else b_cnt++;
            end
            if (bvalid && bready) b_drop = 1;

            if (aw_pend) begin
                chk("awvalid_held", awvalid, 1);
                chk("awaddr_stable", awaddr, prev_awaddr);
            end
            if (awvalid) begin
                aw_cycles++;
                if (aw_cnt >= aw_delay) awready = 1;
                else begin awready = 0; aw_cnt++; end
            end else awready = 0;
            if (awvalid && awready) begin
                aw_got = 1; got_awaddr = awaddr; last_awaddr = awaddr;
                chk("awaddr_aligned", awaddr[1:0], 0);
                last_aw_cycles = aw_cycles; aw_cycles = 0; aw_cnt = 0;
            end
            aw_pend = awvalid && !awready;
            prev_awaddr = awaddr;

            if (wvalid) begin
                w_cycles++;
                if (w_cnt >= w_delay) wready = 1;
                else begin wready = 0; w_cnt++; end
            end else wready = 0;
            if (wvalid && wready) begin
                w_got = 1; got_wdata = wdata;
                last_w_cycles = w_cycles; w_cycles = 0; w_cnt = 0;
            end

            if (ar_pend) begin
                chk("arvalid_held", arvalid, 1);
                chk("araddr_stable", araddr, prev_araddr);
            end
            if (arvalid) begin
                if (ar_cnt >= ar_delay) arready = 1;
                else begin arready = 0; ar_cnt++; end
            end else arready = 0;
            if (arvalid && arready) begin
                ar_got = 1; got_araddr = araddr; last_araddr = araddr; ar_cnt = 0;
                chk("araddr_aligned", araddr[1:0], 0);
            end
            ar_pend = arvalid && !arready;
            prev_araddr = araddr;

            if (ar_got && !rvalid) begin
                if (r_cnt >= r_delay) begin
                    rvalid = 1;
                    rdata  = sub_mem.exists(got_araddr) ? sub_mem[got_araddr] : 32'h0;
                    rresp  = rd_err ? 2'b10 : 2'b00;
                    ar_got = 0; r_cnt = 0;
                end else r_cnt++;
            end
            if (rvalid && rready) r_drop = 1;
        end
    end

    // ---------------- response consumer and scoreboard monitor ----------------
    bit          rsp_pend, rsp_hs_prev;
    int          hold_cnt, rsp_cycles, last_rsp_cycles;
    logic [31:0] prev_rdata;
    logic [1:0]  prev_resp;

    always @(negedge clk) begin
        if (!resetn) begin
            rsp_ready = 0; hold_cnt = 0; rsp_pend = 0; rsp_hs_prev = 0; rsp_cycles = 0;
        end else begin
            if (rsp_hs_prev) chk("cmd_ready_after_rsp", cmd_ready, 1);
            rsp_hs_prev = 0;
            if (rsp_pend) begin
                chk("rsp_valid_held", rsp_valid, 1);
                chk("rsp_rdata_stable", rsp_rdata, prev_rdata);
                chk("rsp_resp_stable", rsp_resp, prev_resp);
            end
            if (rsp_valid) begin
                rsp_cycles++;
                chk("cmd_ready_low_in_rsp", cmd_ready, 0);
                if (hold_cnt >= rsp_hold) rsp_ready = 1;
                else begin rsp_ready = 0; hold_cnt++; end
            end else rsp_ready = 0;
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) fail_now("unexpected_rsp");
                else begin
                    exp_t e;
                    logic [31:0] exp_rd;
                    e = exp_q.pop_front();
                    exp_rd = 32'h0;
                    if (!e.write && ref_mem.exists(e.addr)) exp_rd = ref_mem[e.addr];
                    if (e.write && e.resp == 2'b00) ref_mem[e.addr] = e.wdata;
                    if (e.resp != 2'b00 && ref_err < 255) ref_err++;
                    chk("rsp_write", rsp_write, e.write);
                    chk("rsp_rdata", rsp_rdata, exp_rd);
                    chk("rsp_resp", rsp_resp, e.resp);
                    chk("err_count", err_count, ref_err);
                end
                last_rsp_cycles = rsp_cycles; rsp_cycles = 0; hold_cnt = 0;
                rsp_hs_prev = 1;
            end
            rsp_pend   = rsp_valid && !rsp_ready;
            prev_rdata = rsp_rdata;
            prev_resp  = rsp_resp;
        end
    end

    // ---------------- command driver ----------------
    task automatic do_cmd(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                          input bit wait_rsp);
        exp_t e;
        int   t;
        e.write = wr;
        e.addr  = addr & 32'hFFFF_FFFC;
        e.wdata = data;
        e.resp  = (wr ? wr_err : rd_err) ? 2'b10 : 2'b00;
        exp_q.push_back(e);
        cmd_valid = 1; cmd_write = wr; cmd_addr = addr; cmd_wdata = data;
        t = 0;
        while (!cmd_ready && t < 100) begin @(negedge clk); t++; end
        if (t >= 100) fail_now("cmd_accept_timeout");
        @(negedge clk);
        cmd_valid = 0; cmd_addr = $urandom; cmd_wdata = $urandom; cmd_write = $urandom_range(0, 1);
        if (wait_rsp) begin
            t = 0;
            while (exp_q.size() != 0 && t < 2000) begin @(negedge clk); t++; end
            if (t >= 2000) begin
                fail_now("rsp_timeout");
                exp_q.delete();
            end
        end
    endtask

    initial begin
        resetn = 0; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0;
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_valids", {awvalid, wvalid, arvalid, bready, rready, rsp_valid}, 0);
        chk("rst_err_count", err_count, 0);
        chk("rst_addr_data", {awaddr, araddr, wdata, rsp_rdata}, 0);
        chk("rst_rsp", {rsp_write, rsp_resp}, 0);
        resetn = 1;
        @(negedge clk);

        do_cmd(1, 32'h0, 32'hDEAD_BEEF, 1);
        do_cmd(0, 32'h0, 32'h0, 1);

        aw_delay = 3;
        do_cmd(1, 32'h20, 32'hADAD_ABAB, 1);
        chk("wvalid_cycles", last_w_cycles, 1);
        chk("awvalid_cycles", last_aw_cycles, 4);
        chk("awaddr_0x20", last_awaddr, 32'h20);
        aw_delay = 0;
        do_cmd(0, 32'h20, 32'h0, 1);

        rsp_hold = 5;
        do_cmd(0, 32'h20, 32'h0, 1);
        chk("rsp_valid_cycles", last_rsp_cycles, 6);
        rsp_hold = 0;

        do_cmd(1, 32'h23, 32'h1234_5678, 1);
        chk("awaddr_unaligned", last_awaddr, 32'h20);
        do_cmd(0, 32'h23, 32'h0, 1);
        chk("araddr_unaligned", last_araddr, 32'h20);

        for (int i = 0; i < 80; i++) begin
            aw_delay = $urandom_range(0, 3); w_delay = $urandom_range(0, 3);
            b_delay  = $urandom_range(0, 2); ar_delay = $urandom_range(0, 3);
            r_delay  = $urandom_range(0, 2); rsp_hold = $urandom_range(0, 2);
            wr_err   = ($urandom_range(0, 7) == 0);
            do_cmd($urandom_range(0, 1), $urandom_range(0, 63), $urandom, 1);
        end
        aw_delay = 0; w_delay = 0; b_delay = 0; ar_delay = 0; r_delay = 0;
        rsp_hold = 0; wr_err = 0;

        rd_err = 1;
        for (int i = 0; i < 300; i++) do_cmd(0, $urandom_range(0, 63), 32'h0, 1);
        chk("err_count_saturated", err_count, 8'd255);
        rd_err = 0;
        do_cmd(0, 32'h20, 32'h0, 1);

        aw_delay = 1000;
        do_cmd(1, 32'h30, 32'hCAFE_F00D, 0);
        repeat (3) @(negedge clk);
        chk("midtx_awvalid", awvalid, 1);
        chk("midtx_busy", busy, 1);
        #2 resetn = 0;
        #1;
        chk("async_rst_valids", {awvalid, wvalid, arvalid, bready, rready, rsp_valid}, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_cmd_ready", cmd_ready, 1);
        chk("async_rst_err", err_count, 0);
        chk("async_rst_awaddr", awaddr, 0);
        exp_q.delete();
        ref_err = 0;
        aw_delay = 0;
        @(negedge clk);
        @(negedge clk);
        resetn = 1;
        @(negedge clk);
        do_cmd(0, 32'h30, 32'h0, 1);
        do_cmd(1, 32'h30, 32'h0BAD_CAFE, 1);
        do_cmd(0, 32'h30, 32'h0, 1);

        repeat (3) @(negedge clk);
        chk("final_queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
